avr_cpu_decode: RTL
===================

Name: avr_cpu_decode

Overview:
Decode stage directly downstream of the instruction fetch stage. It consumes the fetched opcode and its cycle index, and returns `hold` and `rjmp` combinationally so that jumps, taken branches and multi-cycle instructions steer the PC in the same cycle. It also registers one stage of execute controls: register addresses, immediate, ALU operation, write enables and SREG mask. It owns skip nullification for SBRC/SBRS and two-cycle sequencing for ADIW, SBIW and MUL.

Parameters:
SREG_W, 8, width of the status register input.
ALU_OP_W, 4, width of the ALU operation code.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
opcode  in  16  current instruction word from fetch.
opcode_cycle  in  1  0 = first cycle of opcode, 1 = second cycle (from fetch).
sreg  in  8  forwarded next-SREG from execute, combinational; order is I,T,H,S,V,N,Z,C (bit 7..0).
rr_addr  out  5  combinational read address to the register file.
rr_data  in  8  combinational read data for rr_addr.
hold  out  1  to fetch: keep the opcode and do not advance the PC.
rjmp  out  12  to fetch: signed PC offset, added to pc+1.
ex_valid  out  1  registered: the execute controls are live.
ex_alu_op  out  4  registered ALU operation (ADD, ADC, SUB, SBC, AND, OR, EOR, MOV, PASS_K, MUL_LO, MUL_HI).
ex_rd  out  5  registered destination / first operand register.
ex_rr  out  5  registered second operand register.
ex_imm  out  8  registered immediate.
ex_use_imm  out  1  registered: second operand is ex_imm.
ex_reg_we  out  1  registered register-file write enable.
ex_sreg_mask  out  8  registered per-bit SREG update enable.
illegal  out  1  registered one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset (rst=0, async): every ex_* output, illegal and skip_pending go to 0. hold=0 and rjmp=0 combinationally while rst=0.
- Supported instructions:
  - NOP 0x0000.
  - ADD, ADC, SUB, SBC, AND, OR, EOR, MOV, CP, CPC (register-register form).
  - CPI, SBCI, SUBI, ORI, ANDI, LDI (Rd = 16 + dddd).
  - RJMP.
  - BRBS, BRBC.
  - SBRC, SBRS.
  - ADIW, SBIW (Rd = 24 + 2*dd).
  - MUL.
  - Anything else decodes as NOP and sets illegal=1 for one cycle.
- Latency: ex_* outputs reflect the opcode presented in the previous cycle (1 register stage).
- rjmp:
  - RJMP: k12.
  - BRBS/BRBC: k7 sign-extended to 12 bits when sreg[s] == 1 / 0 respectively, else 0.
  - All other cases: 0.
- hold: 1 iff the opcode is ADIW, SBIW or MUL, opcode_cycle=0, and the opcode is not being skipped. Otherwise 0.
- ADIW/SBIW:
  - Cycle 0: ex_rd=Rd, ALU op ADD/SUB with K.
  - Cycle 1: ex_rd=Rd+1, ALU op ADC/SBC with imm 0.
  - SREG mask Z,C,N,V,S on both cycles. Execute chains Z across the two cycles.
- MUL:
  - Cycle 0: MUL_LO into r0.
  - Cycle 1: MUL_HI into r1, mask Z,C.
- CP, CPC, CPI: ex_reg_we=0, SREG mask is still applied.
- SBRC/SBRS:
  - rr_addr = r field; test rr_data[b].
  - If the skip condition holds, set skip_pending=1 at the clock edge.
- rr_addr for the register-register forms = r field. Otherwise don't-care, but held stable.
- skip_pending=1 with a new opcode:
  - That opcode is nullified: ex_valid=0, ex_reg_we=0, mask 0, hold=0, rjmp=0, no illegal pulse.
  - skip_pending clears. Only one-word skips are supported.
  - A skipped SBRC/SBRS does not evaluate its own skip.
  - A skipped ADIW/SBIW/MUL does not hold.
- Async reset asserted during cycle 0 of a two-cycle instruction: all state is cleared immediately and no cycle-1 controls are ever issued.
- Offsets: RJMP .-1 (k=0xFFF) loops on itself. Offsets wrap in fetch PC arithmetic; decode performs no range check.

Decomposition:
- Shared include avr_cpu_defs.vh holds:
  - ALU op codes.
  - SREG bit indices (C=0 ... I=7).
  - Opcode match masks/values.
- Natural sub-module: avr_cpu_decode_table. It is purely combinational: opcode + opcode_cycle → next-state controls, hold_req, is_skip_op and branch fields. The top level holds skip_pending, the output registers and the rjmp/hold gating.

Test Plan:
- LDI r16,0x55 (0xE505) → next cycle: ex_valid=1, ex_rd=16, ex_imm=0x55, ex_use_imm=1, ex_alu_op=PASS_K, ex_reg_we=1; hold=0, rjmp=0.
- RJMP .-1 (0xCFFF) → same cycle rjmp=0xFFF, hold=0.
- BRBS Z,+1 (0xF009):
  - sreg=0x02 → rjmp=0x001.
  - sreg=0x00 → rjmp=0x000.
  - Repeat with BRBC (0xF409); expect the inverse result.
- SBRS r0,0 (0xFE00) with rr_data=0x01, followed by LDI 0xE505 → rr_addr=0. The LDI's ex cycle shows ex_valid=0, ex_reg_we=0. The instruction after it executes normally.
  - With rr_data=0x00 the LDI executes normally.
- ADIW r24,1 (0x9601):
  - opcode_cycle=0 → hold=1; next ex_rd=24, ADD, imm 1.
  - opcode_cycle=1 → hold=0; next ex_rd=25, ADC, imm 0.
- Drive rst=0 mid-ADIW (cycle 0) asynchronously → all ex_* outputs, illegal and hold go to 0 immediately. Opcode 0xFFFF → illegal pulses 1 cycle, ex_valid=0.

Source files
------------

// File: rtl/avr_cpu_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_decode_pkg
// Purpose  : ALU op codes, SREG bit map, opcode match tables and the execute
//            control bundle shared by the AVR decode stage.
// Revision : 1.0 - initial release
// ============================================================================
package avr_cpu_decode_pkg;

    localparam int SREG_W_DEF   = 8;
    localparam int ALU_OP_W_DEF = 4;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_ADC    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_SBC    = 4'd3,
        ALU_AND    = 4'd4,
        ALU_OR     = 4'd5,
        ALU_EOR    = 4'd6,
        ALU_MOV    = 4'd7,
        ALU_PASS_K = 4'd8,
        ALU_MUL_LO = 4'd9,
        ALU_MUL_HI = 4'd10
    } alu_op_e;

    typedef enum int {
        SREG_C = 0, SREG_Z = 1, SREG_N = 2, SREG_V = 3,
        SREG_S = 4, SREG_H = 5, SREG_T = 6, SREG_I = 7
    } sreg_bit_e;

    // SREG update masks, bit order I,T,H,S,V,N,Z,C
    localparam logic [7:0] SM_NONE  = 8'b0000_0000;
    localparam logic [7:0] SM_ARITH = 8'b0011_1111;
    localparam logic [7:0] SM_LOGIC = 8'b0001_1110;
    localparam logic [7:0] SM_WORD  = 8'b0001_1111;
    localparam logic [7:0] SM_ZC    = 8'b0000_0011;

    localparam logic [15:0] OP_NOP  = 16'h0000;

    localparam logic [15:0] M_RR    = 16'hFC00;
    localparam logic [15:0] V_ADD   = 16'h0C00;
    localparam logic [15:0] V_ADC   = 16'h1C00;
    localparam logic [15:0] V_SUB   = 16'h1800;
    localparam logic [15:0] V_SBC   = 16'h0800;
    localparam logic [15:0] V_AND   = 16'h2000;
    localparam logic [15:0] V_EOR   = 16'h2400;
    localparam logic [15:0] V_OR    = 16'h2800;
    localparam logic [15:0] V_MOV   = 16'h2C00;
    localparam logic [15:0] V_CP    = 16'h1400;
    localparam logic [15:0] V_CPC   = 16'h0400;
    localparam logic [15:0] V_MUL   = 16'h9C00;

    localparam logic [15:0] M_IMM   = 16'hF000;
    localparam logic [15:0] V_CPI   = 16'h3000;
    localparam logic [15:0] V_SBCI  = 16'h4000;
    localparam logic [15:0] V_SUBI  = 16'h5000;
    localparam logic [15:0] V_ORI   = 16'h6000;
    localparam logic [15:0] V_ANDI  = 16'h7000;
    localparam logic [15:0] V_LDI   = 16'hE000;
    localparam logic [15:0] V_RJMP  = 16'hC000;

    // BRBS/BRBC differ only in bit 10; SBRC/SBRS only in bit 9
    localparam logic [15:0] M_BRBX  = 16'hF800;
    localparam logic [15:0] V_BRBX  = 16'hF000;
    localparam logic [15:0] M_SBRX  = 16'hFC08;
    localparam logic [15:0] V_SBRX  = 16'hFC00;

    localparam logic [15:0] M_IW    = 16'hFF00;
    localparam logic [15:0] V_ADIW  = 16'h9600;
    localparam logic [15:0] V_SBIW  = 16'h9700;

    typedef struct packed {
        logic       valid;
        alu_op_e    alu_op;
        logic [4:0] rd;
        logic [4:0] rr;
        logic [7:0] imm;
        logic       use_imm;
        logic       reg_we;
        logic [7:0] sreg_mask;
    } ex_ctrl_t;

    function automatic logic op_is(input logic [15:0] op, input logic [15:0] mask,
                                   input logic [15:0] val);
        return (op & mask) == val;
    endfunction

    function automatic ex_ctrl_t mk_ctrl(input alu_op_e op, input logic [4:0] rd,
                                         input logic [4:0] rr, input logic [7:0] imm,
                                         input logic use_imm, input logic we,
                                         input logic [7:0] mask);
        ex_ctrl_t c;
        c.valid     = 1'b1;
        c.alu_op    = op;
        c.rd        = rd;
        c.rr        = rr;
        c.imm       = imm;
        c.use_imm   = use_imm;
        c.reg_we    = we;
        c.sreg_mask = mask;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avr_cpu_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_decode_if
// Purpose  : Fetch/regfile/execute facing bundle of the AVR decode stage.
// Revision : 1.0 - initial release
// ============================================================================
interface avr_cpu_decode_if #(
    parameter int SREG_W   = 8,
    parameter int ALU_OP_W = 4
);
    logic [15:0]         opcode;
    logic                opcode_cycle;
    logic [SREG_W-1:0]   sreg;
    logic [4:0]          rr_addr;
    logic [7:0]          rr_data;
    logic                hold;
    logic [11:0]         rjmp;
    logic                ex_valid;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic [4:0]          ex_rd;
    logic [4:0]          ex_rr;
    logic [7:0]          ex_imm;
    logic                ex_use_imm;
    logic                ex_reg_we;
    logic [SREG_W-1:0]   ex_sreg_mask;
    logic                illegal;

    modport master (
        output opcode, opcode_cycle, sreg, rr_data,
        input  rr_addr, hold, rjmp, ex_valid, ex_alu_op, ex_rd, ex_rr, ex_imm,
               ex_use_imm, ex_reg_we, ex_sreg_mask, illegal
    );

    modport slave (
        input  opcode, opcode_cycle, sreg, rr_data,
        output rr_addr, hold, rjmp, ex_valid, ex_alu_op, ex_rd, ex_rr, ex_imm,
               ex_use_imm, ex_reg_we, ex_sreg_mask, illegal
    );
endinterface
`default_nettype wire

// File: rtl/avr_cpu_decode_table.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_decode_table
// Purpose  : Purely combinational opcode decode into execute controls and
//            flow-control fields (jump, branch, skip, hold request).
// Revision : 1.0 - initial release
// ============================================================================
module avr_cpu_decode_table
    import avr_cpu_decode_pkg::*;
(
    input  logic [15:0] opcode_i,
    input  logic        opcode_cycle_i,
    output ex_ctrl_t    ctrl_o,
    output logic        illegal_o,
    output logic        hold_req_o,
    output logic        is_skip_op_o,
    output logic        skip_set_o,
    output logic [2:0]  skip_bit_o,
    output logic [4:0]  rr_addr_o,
    output logic        is_rjmp_o,
    output logic        is_branch_o,
    output logic        branch_set_o,
    output logic [2:0]  branch_bit_o,
    output logic [11:0] k12_o,
    output logic [6:0]  k7_o
);

    logic [4:0] w_rd_rr;
    logic [4:0] w_rr_rr;
    logic [4:0] w_rd_imm;
    logic [4:0] w_rd_word_lo;
    logic [4:0] w_rd_word_hi;
    logic [7:0] w_k8;
    logic [7:0] w_k6;
    logic       w_first;

    assign w_rd_rr      = {opcode_i[8], opcode_i[7:4]};
    assign w_rr_rr      = {opcode_i[9], opcode_i[3:0]};
    assign w_rd_imm     = {1'b1, opcode_i[7:4]};
    assign w_rd_word_lo = {2'b11, opcode_i[5:4], 1'b0};
    assign w_rd_word_hi = {2'b11, opcode_i[5:4], 1'b1};
    assign w_k8         = {opcode_i[11:8], opcode_i[3:0]};
    assign w_k6         = {2'b00, opcode_i[7:6], opcode_i[3:0]};
    assign w_first      = !opcode_cycle_i;

    assign skip_set_o   = opcode_i[9];
    assign skip_bit_o   = opcode_i[2:0];
    assign branch_set_o = !opcode_i[10];
    assign branch_bit_o = opcode_i[2:0];
    assign k12_o        = opcode_i[11:0];
    assign k7_o         = opcode_i[9:3];
    assign rr_addr_o    = op_is(opcode_i, M_SBRX, V_SBRX) ? opcode_i[8:4] : w_rr_rr;

    always_comb begin
        ctrl_o       = '0;
        illegal_o    = 1'b0;
        hold_req_o   = 1'b0;
        is_skip_op_o = 1'b0;
        is_rjmp_o    = 1'b0;
        is_branch_o  = 1'b0;
        if (opcode_i == OP_NOP) begin
            ctrl_o = '0;
        end else if (op_is(opcode_i, M_RR, V_ADD)) begin
            ctrl_o = mk_ctrl(ALU_ADD, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b1, SM_ARITH);
        end else if (op_is(opcode_i, M_RR, V_ADC)) begin
            ctrl_o = mk_ctrl(ALU_ADC, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b1, SM_ARITH);
        end else if (op_is(opcode_i, M_RR, V_SUB)) begin
            ctrl_o = mk_ctrl(ALU_SUB, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b1, SM_ARITH);
        end else if (op_is(opcode_i, M_RR, V_SBC)) begin
            ctrl_o = mk_ctrl(ALU_SBC, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b1, SM_ARITH);
        end else if (op_is(opcode_i, M_RR, V_AND)) begin
            ctrl_o = mk_ctrl(ALU_AND, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b1, SM_LOGIC);
        end else if (op_is(opcode_i, M_RR, V_EOR)) begin
            ctrl_o = mk_ctrl(ALU_EOR, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b1, SM_LOGIC);
        end else if (op_is(opcode_i, M_RR, V_OR)) begin
            ctrl_o = mk_ctrl(ALU_OR, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b1, SM_LOGIC);
        end else if (op_is(opcode_i, M_RR, V_MOV)) begin
            ctrl_o = mk_ctrl(ALU_MOV, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b1, SM_NONE);
        end else if (op_is(opcode_i, M_RR, V_CP)) begin
            ctrl_o = mk_ctrl(ALU_SUB, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b0, SM_ARITH);
        end else if (op_is(opcode_i, M_RR, V_CPC)) begin
            ctrl_o = mk_ctrl(ALU_SBC, w_rd_rr, w_rr_rr, 8'h00, 1'b0, 1'b0, SM_ARITH);
        end else if (op_is(opcode_i, M_RR, V_MUL)) begin
            // ex_rd names the product half; the multiplicand index rides in ex_imm
            hold_req_o = w_first;
            if (w_first)
                ctrl_o = mk_ctrl(ALU_MUL_LO, 5'd0, w_rr_rr, {3'b000, w_rd_rr}, 1'b0, 1'b1, SM_NONE);
            else
                ctrl_o = mk_ctrl(ALU_MUL_HI, 5'd1, w_rr_rr, {3'b000, w_rd_rr}, 1'b0, 1'b1, SM_ZC);
        end else if (op_is(opcode_i, M_IMM, V_CPI)) begin
            ctrl_o = mk_ctrl(ALU_SUB, w_rd_imm, 5'd0, w_k8, 1'b1, 1'b0, SM_ARITH);
        end else if (op_is(opcode_i, M_IMM, V_SBCI)) begin
            ctrl_o = mk_ctrl(ALU_SBC, w_rd_imm, 5'd0, w_k8, 1'b1, 1'b1, SM_ARITH);
        end else if (op_is(opcode_i, M_IMM, V_SUBI)) begin
            ctrl_o = mk_ctrl(ALU_SUB, w_rd_imm, 5'd0, w_k8, 1'b1, 1'b1, SM_ARITH);
        end else if (op_is(opcode_i, M_IMM, V_ORI)) begin
            ctrl_o = mk_ctrl(ALU_OR, w_rd_imm, 5'd0, w_k8, 1'b1, 1'b1, SM_LOGIC);
        end else if (op_is(opcode_i, M_IMM, V_ANDI)) begin
            ctrl_o = mk_ctrl(ALU_AND, w_rd_imm, 5'd0, w_k8, 1'b1, 1'b1, SM_LOGIC);
        end else if (op_is(opcode_i, M_IMM, V_LDI)) begin
            ctrl_o = mk_ctrl(ALU_PASS_K, w_rd_imm, 5'd0, w_k8, 1'b1, 1'b1, SM_NONE);
        end else if (op_is(opcode_i, M_IMM, V_RJMP)) begin
            is_rjmp_o = 1'b1;
        end else if (op_is(opcode_i, M_BRBX, V_BRBX)) begin
            is_branch_o = 1'b1;
        end else if (op_is(opcode_i, M_SBRX, V_SBRX)) begin
            is_skip_op_o = 1'b1;
        end else if (op_is(opcode_i, M_IW, V_ADIW)) begin
            hold_req_o = w_first;
            if (w_first)
                ctrl_o = mk_ctrl(ALU_ADD, w_rd_word_lo, 5'd0, w_k6, 1'b1, 1'b1, SM_WORD);
            else
                ctrl_o = mk_ctrl(ALU_ADC, w_rd_word_hi, 5'd0, 8'h00, 1'b1, 1'b1, SM_WORD);
        end else if (op_is(opcode_i, M_IW, V_SBIW)) begin
            hold_req_o = w_first;
            if (w_first)
                ctrl_o = mk_ctrl(ALU_SUB, w_rd_word_lo, 5'd0, w_k6, 1'b1, 1'b1, SM_WORD);
            else
                ctrl_o = mk_ctrl(ALU_SBC, w_rd_word_hi, 5'd0, 8'h00, 1'b1, 1'b1, SM_WORD);
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/avr_cpu_decode.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_decode
// Purpose  : AVR decode stage: same-cycle hold/rjmp to fetch, one registered
//            stage of execute controls, SBRC/SBRS skip nullification.
// Revision : 1.0 - initial release
// ============================================================================
module avr_cpu_decode
    import avr_cpu_decode_pkg::*;
#(
    parameter int SREG_W   = SREG_W_DEF,
    parameter int ALU_OP_W = ALU_OP_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    avr_cpu_decode_if.slave bus
);

    ex_ctrl_t          ex_q;
    ex_ctrl_t          ex_d;
    logic              illegal_q;
    logic              illegal_d;
    logic              skip_pending_q;
    logic              skip_pending_d;

    ex_ctrl_t          w_tbl_ctrl;
    logic              w_tbl_illegal;
    logic              w_hold_req;
    logic              w_is_skip_op;
    logic              w_skip_set;
    logic [2:0]        w_skip_bit;
    logic              w_is_rjmp;
    logic              w_is_branch;
    logic              w_branch_set;
    logic [2:0]        w_branch_bit;
    logic [11:0]       w_k12;
    logic [6:0]        w_k7;
    logic [SREG_W-1:0] w_sreg;
    logic              w_live;
    logic              w_branch_taken;
    logic [11:0]       w_rjmp;

    avr_cpu_decode_table u_table (
        .opcode_i       (bus.opcode),
        .opcode_cycle_i (bus.opcode_cycle),
        .ctrl_o         (w_tbl_ctrl),
        .illegal_o      (w_tbl_illegal),
        .hold_req_o     (w_hold_req),
        .is_skip_op_o   (w_is_skip_op),
        .skip_set_o     (w_skip_set),
        .skip_bit_o     (w_skip_bit),
        .rr_addr_o      (bus.rr_addr),
        .is_rjmp_o      (w_is_rjmp),
        .is_branch_o    (w_is_branch),
        .branch_set_o   (w_branch_set),
        .branch_bit_o   (w_branch_bit),
        .k12_o          (w_k12),
        .k7_o           (w_k7)
    );

    assign w_sreg = bus.sreg;

    // An opcode following a taken skip is architecturally absent: no steering
    assign w_live         = rst && !skip_pending_q;
    assign w_branch_taken = w_is_branch && (w_sreg[w_branch_bit] == w_branch_set);

    always_comb begin
        w_rjmp = 12'h000;
        if (w_is_rjmp)
            w_rjmp = w_k12;
        else if (w_branch_taken)
            w_rjmp = {{5{w_k7[6]}}, w_k7};
    end

    assign bus.rjmp = w_live ? w_rjmp : 12'h000;
    assign bus.hold = w_live && w_hold_req;

    always_comb begin
        ex_d           = w_tbl_ctrl;
        illegal_d      = w_tbl_illegal;
        skip_pending_d = 1'b0;
        if (skip_pending_q) begin
            ex_d      = '0;
            illegal_d = 1'b0;
        end else if (w_is_skip_op) begin
            skip_pending_d = (bus.rr_data[w_skip_bit] == w_skip_set);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q           <= '0;
            illegal_q      <= 1'b0;
            skip_pending_q <= 1'b0;
        end else begin
            ex_q           <= ex_d;
            illegal_q      <= illegal_d;
            skip_pending_q <= skip_pending_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_alu_op    = ALU_OP_W'(ex_q.alu_op);
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_rr        = ex_q.rr;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_use_imm   = ex_q.use_imm;
    assign bus.ex_reg_we    = ex_q.reg_we;
    assign bus.ex_sreg_mask = SREG_W'(ex_q.sreg_mask);
    assign bus.illegal      = illegal_q;

endmodule
`default_nettype wire
